// File: rtl/if_fetch_align_pkg.sv
// Shared types and constants for the instruction-fetch/align stage.
package if_fetch_align_pkg;

  localparam int unsigned FETCH_DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

  typedef logic [31:0] fetch_word_t;

  // Instruction handed to decode: word, size flag and its PC
  typedef struct packed {
    fetch_word_t instr;
    logic        compressed;
    fetch_word_t pc;
  } fetch_instr_t;

  // RVC encodings never have 2'b11 in the two low bits
  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/if_fetch_align_if.sv
// Program-memory, redirect and decode handshake bundle of the fetch stage.
interface if_fetch_align_if;
  import if_fetch_align_pkg::*;

  fetch_word_t pmAddr;
  logic        pmReq;
  fetch_word_t pmData;
  logic        redirectEn;
  fetch_word_t redirectPc;
  fetch_word_t instrIF;
  logic        instrCompressedIF;
  fetch_word_t pcIF;
  logic        instrValidIF;
  logic        instrReadyIF;

  // Fetch stage side
  modport master (
    output pmAddr, pmReq, instrIF, instrCompressedIF, pcIF, instrValidIF,
    input  pmData, redirectEn, redirectPc, instrReadyIF
  );

  // Memory / decode / redirect-source side
  modport slave (
    input  pmAddr, pmReq, instrIF, instrCompressedIF, pcIF, instrValidIF,
    output pmData, redirectEn, redirectPc, instrReadyIF
  );

endinterface

// File: rtl/if_fetch_align_fetch_word_fifo.sv
// Small word FIFO with synchronous clear and a peek at the two oldest entries.
module if_fetch_align_fetch_word_fifo
  import if_fetch_align_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  fetch_word_t push_data,
  input  logic        pop,
  output fetch_word_t head,
  output logic [15:0] head_next_lo,
  output logic [CW-1:0] count
);

  fetch_word_t   mem_q [DEPTH];
  fetch_word_t   mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer/count update; clear wins over push and pop
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; only pointers and count are cleared
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Only the low half of head+1 is ever needed (straddling instruction)
  assign head         = mem_q[rd_ptr_q];
  assign head_next_lo = mem_q[rd_ptr_q + AW'(1)][15:0];
  assign count        = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr)
                                  !(push && count_q == CW'(DEPTH)));

endmodule

// File: rtl/if_fetch_align.sv
// Fetch stage: word requests to program memory, word FIFO, 16/32-bit aligner.
module if_fetch_align
  import if_fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  if_fetch_align_if.master bus
);

  localparam int unsigned CW = $clog2(FETCH_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  fetch_word_t pc_q, pc_d;
  fetch_word_t fetch_addr_q, fetch_addr_d;
  logic        req_pending_q, req_pending_d;

  fetch_word_t   w0;
  logic [15:0]   w1_lo;
  logic [CW-1:0] count;
  logic          push, pop, pm_req;

  logic [15:0]  half;
  logic         half_c, have_one, have_two, instr_valid, fire;
  fetch_instr_t out_c;

  if_fetch_align_fetch_word_fifo #(.DEPTH(FETCH_DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clr          (bus.redirectEn),
    .push         (push),
    .push_data    (bus.pmData),
    .pop          (pop),
    .head         (w0),
    .head_next_lo (w1_lo),
    .count        (count)
  );

  // Request issue: the in-flight word counts against FIFO space; a response
  // arriving during a redirect belongs to the old stream and is dropped
  always_comb begin
    pm_req = 1'b0;
    if (!rst && !bus.redirectEn) begin
      pm_req = (OW'(count) + OW'(req_pending_q)) < OW'(FETCH_DEPTH);
    end
    push = req_pending_q && !bus.redirectEn;
  end

  // Aligner: pick the halfword at pc, decide size and whether w1 is needed
  always_comb begin
    half        = pc_q[1] ? w0[31:16] : w0[15:0];
    half_c      = is_compressed(half);
    have_one    = count != '0;
    have_two    = count >= CW'(2);
    instr_valid = !rst && !bus.redirectEn &&
                  (have_two || (have_one && !(pc_q[1] && !half_c)));
    fire        = instr_valid && bus.instrReadyIF;
    // w0 is consumed once its upper half has been used
    pop         = fire && (pc_q[1] || !half_c);
    out_c.instr      = half_c ? {16'h0000, half}
                              : (pc_q[1] ? {w1_lo, w0[31:16]} : w0);
    out_c.compressed = half_c;
    out_c.pc         = pc_q;
  end

  // Next PC / fetch address; redirect overrides the handshake
  always_comb begin
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    req_pending_d = pm_req;
    if (bus.redirectEn) begin
      pc_d         = bus.redirectPc & 32'hFFFF_FFFE;
      fetch_addr_d = bus.redirectPc & 32'hFFFF_FFFC;
    end else begin
      if (fire) begin
        pc_d = pc_q + (half_c ? 32'd2 : 32'd4);
      end
      if (pm_req) begin
        fetch_addr_d = fetch_addr_q + 32'd4;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      fetch_addr_q  <= RESET_PC & 32'hFFFF_FFFC;
      req_pending_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      req_pending_q <= req_pending_d;
    end
  end

  assign bus.pmReq             = pm_req;
  assign bus.pmAddr            = fetch_addr_q;
  assign bus.instrIF           = out_c.instr;
  assign bus.instrCompressedIF = out_c.compressed;
  assign bus.pcIF              = out_c.pc;
  assign bus.instrValidIF      = instr_valid;

endmodule

// File: tb/tb_if_fetch_align.sv
// Self-checking bench for if_fetch_align against a program-order stream model.
module tb_if_fetch_align;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] mem [256];
  logic [31:0] rsp_addr;
  logic [31:0] exp_pc;

  if_fetch_align_if bus();

  if_fetch_align #(.RESET_PC(32'h0000_0000), .FETCH_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fixed one-cycle read latency, 1 KiB aliased
  always @(posedge clk) rsp_addr <= bus.pmAddr;
  assign bus.pmData = mem[rsp_addr[9:2]];

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction starting at byte address a, in program order
  function automatic logic [31:0] ref_instr(input logic [31:0] a);
    logic [15:0] h;
    h = half_at(a);
    if (h[1:0] != 2'b11) return {16'h0000, h};
    return {half_at(a + 32'd2), h};
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic fill_random();
    logic [15:0] lo, hi;
    for (int i = 0; i < 256; i++) begin
      lo = 16'($urandom);
      hi = 16'($urandom);
      if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11;
      mem[i] = {hi, lo};
    end
  endtask

  // Returns at the falling edge on which rst is released
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.redirectEn = 1'b0;
    bus.redirectPc = 32'h0;
    bus.instrReadyIF = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Accept n instructions with random ready and compare each to the model
  task automatic test_stream(input int n, input int ready_pct);
    int got, budget;
    logic [31:0] e_ins;
    logic e_c;
    got = 0;
    budget = n * 10 + 40;
    while (got < n && budget > 0) begin
      @(negedge clk);
      bus.instrReadyIF = ($urandom_range(0, 99) < ready_pct);
      #1;
      budget--;
      if (bus.instrValidIF && bus.instrReadyIF) begin
        e_ins = ref_instr(exp_pc);
        e_c = (e_ins[1:0] != 2'b11);
        n_cmp++;
        if (bus.pcIF !== exp_pc || bus.instrIF !== e_ins || bus.instrCompressedIF !== e_c) begin
          n_err++;
          $display("FAIL stream: got pc=%h ins=%h c=%b, want pc=%h ins=%h c=%b",
                   bus.pcIF, bus.instrIF, bus.instrCompressedIF, exp_pc, e_ins, e_c);
        end
        exp_pc = exp_pc + (e_c ? 32'd2 : 32'd4);
        got++;
      end
    end
    if (got < n) begin
      n_cmp++;
      n_err++;
      $display("FAIL stream_timeout: got %0d instructions, want %0d", got, n);
    end
    @(negedge clk);
    bus.instrReadyIF = 1'b0;
  endtask

  task automatic test_reset();
    fill_nop();
    @(negedge clk);
    rst = 1'b1;
    bus.instrReadyIF = 1'b1;
    bus.redirectEn = 1'b0;
    #1;
    n_cmp++;
    if (bus.instrValidIF !== 1'b0 || bus.pmReq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b req=%b, want 0 0", bus.instrValidIF, bus.pmReq);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.pmReq !== 1'b1 || bus.pmAddr !== 32'h0 || bus.instrValidIF !== 1'b0) begin
      n_err++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, want 1 0 0",
               bus.pmReq, bus.pmAddr, bus.instrValidIF);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.pmReq !== 1'b1 || bus.pmAddr !== 32'h4 || bus.instrValidIF !== 1'b0) begin
      n_err++;
      $display("FAIL second_req: req=%b addr=%h valid=%b, want 1 4 0",
               bus.pmReq, bus.pmAddr, bus.instrValidIF);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.instrValidIF !== 1'b1 || bus.pcIF !== 32'(4 * k) || bus.instrIF !== 32'h13 ||
          bus.pmAddr !== 32'(4 * k + 8)) begin
        n_err++;
        $display("FAIL nop_stream[%0d]: valid=%b pc=%h ins=%h addr=%h, want 1 %h 13 %h", k,
                 bus.instrValidIF, bus.pcIF, bus.instrIF, bus.pmAddr, 4 * k, 4 * k + 8);
      end
    end
    @(negedge clk);
    bus.instrReadyIF = 1'b0;
  endtask

  task automatic test_compressed();
    logic [31:0] epc [3] = '{32'h0, 32'h2, 32'h4};
    logic [31:0] eins [3] = '{32'h0000_4081, 32'h0000_4501, 32'h0000_0013};
    logic        ec [3] = '{1'b1, 1'b1, 1'b0};
    int b;
    fill_nop();
    mem[0] = 32'h4501_4081;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      b = 0;
      do begin
        @(negedge clk);
        #1;
        b++;
      end while (!bus.instrValidIF && b < 20);
      n_cmp++;
      if (bus.instrValidIF !== 1'b1 || bus.pcIF !== epc[i] || bus.instrIF !== eins[i] ||
          bus.instrCompressedIF !== ec[i]) begin
        n_err++;
        $display("FAIL compressed[%0d]: valid=%b pc=%h ins=%h c=%b, want 1 %h %h %b", i,
                 bus.instrValidIF, bus.pcIF, bus.instrIF, bus.instrCompressedIF,
                 epc[i], eins[i], ec[i]);
      end
    end
    @(negedge clk);
    bus.instrReadyIF = 1'b0;
  endtask

  task automatic test_straddle();
    logic [31:0] epc [4] = '{32'h0, 32'h2, 32'h6, 32'h8};
    logic [31:0] eins [4] = '{32'h0000_4081, 32'h0000_0513, 32'h0000_0001, 32'h0000_0013};
    logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int b;
    fill_nop();
    mem[0] = 32'h0513_4081;
    mem[1] = 32'h0001_0000;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      b = 0;
      do begin
        @(negedge clk);
        #1;
        b++;
      end while (!bus.instrValidIF && b < 20);
      n_cmp++;
      if (bus.instrValidIF !== 1'b1 || bus.pcIF !== epc[i] || bus.instrIF !== eins[i] ||
          bus.instrCompressedIF !== ec[i]) begin
        n_err++;
        $display("FAIL straddle[%0d]: valid=%b pc=%h ins=%h c=%b, want 1 %h %h %b", i,
                 bus.instrValidIF, bus.pcIF, bus.instrIF, bus.instrCompressedIF,
                 epc[i], eins[i], ec[i]);
      end
    end
    @(negedge clk);
    bus.instrReadyIF = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] hold_pc, hold_ins;
    int b;
    fill_random();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0000_0013;
    reset_dut();
    b = 0;
    do begin
      @(negedge clk);
      #1;
      b++;
    end while (!bus.instrValidIF && b < 20);
    @(negedge clk);
    bus.instrReadyIF = 1'b0;
    #1;
    hold_pc = bus.pcIF;
    hold_ins = bus.instrIF;
    n_cmp++;
    if (bus.instrValidIF !== 1'b1 || hold_pc !== 32'h4) begin
      n_err++;
      $display("FAIL stall_entry: valid=%b pc=%h, want 1 4", bus.instrValidIF, hold_pc);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.instrValidIF !== 1'b1 || bus.pcIF !== hold_pc || bus.instrIF !== hold_ins) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h ins=%h, want 1 %h %h", k,
                 bus.instrValidIF, bus.pcIF, bus.instrIF, hold_pc, hold_ins);
      end
    end
    n_cmp++;
    if (bus.pmReq !== 1'b0) begin
      n_err++;
      $display("FAIL stall_full_req: req=%b, want 0", bus.pmReq);
    end
    exp_pc = hold_pc;
    test_stream(24, 100);
  endtask

  task automatic test_redirect();
    fill_random();
    reset_dut();
    exp_pc = 32'h0;
    test_stream(8, 100);
    @(negedge clk);
    bus.redirectEn = 1'b1;
    bus.redirectPc = 32'h0000_0102;
    bus.instrReadyIF = 1'b1;
    #1;
    n_cmp++;
    if (bus.instrValidIF !== 1'b0 || bus.pmReq !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_cycle: valid=%b req=%b, want 0 0", bus.instrValidIF, bus.pmReq);
    end
    @(negedge clk);
    bus.redirectEn = 1'b0;
    #1;
    n_cmp++;
    if (bus.pmReq !== 1'b1 || bus.pmAddr !== 32'h100 || bus.instrValidIF !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_req: req=%b addr=%h valid=%b, want 1 100 0",
               bus.pmReq, bus.pmAddr, bus.instrValidIF);
    end
    exp_pc = 32'h0000_0102;
    test_stream(20, 100);
  endtask

  task automatic test_random_redirect();
    logic [31:0] tgt;
    fill_random();
    reset_dut();
    exp_pc = 32'h0;
    test_stream(10, 60);
    for (int r = 0; r < 6; r++) begin
      tgt = 32'($urandom_range(0, 511)) * 32'd2;
      @(negedge clk);
      bus.redirectEn = 1'b1;
      bus.redirectPc = tgt | 32'($urandom_range(0, 1));
      bus.instrReadyIF = ($urandom_range(0, 1) == 1);
      #1;
      n_cmp++;
      if (bus.instrValidIF !== 1'b0 || bus.pmReq !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_redirect_cycle[%0d]: valid=%b req=%b, want 0 0", r,
                 bus.instrValidIF, bus.pmReq);
      end
      @(negedge clk);
      bus.redirectEn = 1'b0;
      #1;
      n_cmp++;
      if (bus.pmReq !== 1'b1 || bus.pmAddr !== (tgt & 32'hFFFF_FFFC)) begin
        n_err++;
        $display("FAIL rnd_redirect_req[%0d]: req=%b addr=%h, want 1 %h", r,
                 bus.pmReq, bus.pmAddr, tgt & 32'hFFFF_FFFC);
      end
      exp_pc = tgt;
      test_stream(15, 60);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    fill_nop();
    reset_dut();
    b = 0;
    do begin
      @(negedge clk);
      #1;
      b++;
    end while (!bus.instrValidIF && b < 20);
    @(negedge clk);
    bus.instrReadyIF = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    bus.instrReadyIF = 1'b1;
    #1;
    n_cmp++;
    if (bus.instrValidIF !== 1'b0 || bus.pmReq !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_cycle: valid=%b req=%b, want 0 0", bus.instrValidIF, bus.pmReq);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.pmReq !== 1'b1 || bus.pmAddr !== 32'h0 || bus.instrValidIF !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_first_req: req=%b addr=%h valid=%b, want 1 0 0",
               bus.pmReq, bus.pmAddr, bus.instrValidIF);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.pmAddr !== 32'h4 || bus.instrValidIF !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_second: addr=%h valid=%b, want 4 0", bus.pmAddr, bus.instrValidIF);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.instrValidIF !== 1'b1 || bus.pcIF !== 32'h0 || bus.instrIF !== 32'h13) begin
      n_err++;
      $display("FAIL midrst_first_valid: valid=%b pc=%h ins=%h, want 1 0 13",
               bus.instrValidIF, bus.pcIF, bus.instrIF);
    end
    @(negedge clk);
    bus.instrReadyIF = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_pc = 32'h0;
    rst = 1'b1;
    bus.redirectEn = 1'b0;
    bus.redirectPc = 32'h0;
    bus.instrReadyIF = 1'b0;
    fill_nop();
    repeat (2) @(negedge clk);
    test_reset();
    test_compressed();
    test_straddle();
    test_stall();
    test_redirect();
    test_random_redirect();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_align.md
Name: if_fetch_align

Overview:
- Instruction-fetch stage of the rv32imc core.
- Issues word-aligned requests to program memory and buffers the returned words in a small FIFO.
- Aligns 16-bit and 32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Hands one instruction per cycle, with its PC, to the decode stage over a valid/ready handshake; branch/jump redirects flush it.

Parameters:
- RESET_PC, 32'h0000_0000, first instruction address after reset; bit 0 must be 0.
- FETCH_DEPTH, 4, word FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- pmAddr  out  32  word-aligned program-memory address; bits [1:0] always 0.
- pmReq  out  1  fetch request issued this cycle.
- pmData  in  32  read word; valid in the cycle after pmReq was high (fixed 1-cycle latency).
- redirectEn  in  1  flush and restart fetch.
- redirectPc  in  32  restart address; bit 0 ignored.
- instrIF  out  32  instruction; compressed instructions are zero-extended to {16'h0, half}.
- instrCompressedIF  out  1  instrIF holds a 16-bit instruction.
- pcIF  out  32  PC of instrIF, halfword-aligned.
- instrValidIF  out  1  instrIF/pcIF are valid.
- instrReadyIF  in  1  decode accepts the instruction; low stalls the stage.

Behaviour:
- Reset (synchronous, active-high; overrides all other inputs in the same cycle):
  - Registers: pc=RESET_PC, fetchAddr={RESET_PC[31:2],2'b00}, FIFO count=0, reqPending=0.
  - Outputs: pmReq=0, instrValidIF=0.
- Request issue:
  - pmReq = !rst && !redirectEn && (count + reqPending + (pushing?0:0)) < FETCH_DEPTH. The occupancy check includes the word in flight (reqPending). It must not count a word being popped this cycle; the check is conservative.
  - pmAddr = fetchAddr. fetchAddr += 4 on each request; wraps modulo 2^32.
  - reqPending <= pmReq.
- Response: when reqPending is high and redirectEn is low, push pmData into the FIFO at the clock edge.
- Aligner (combinational from the FIFO head w0 and next entry w1); h = pc[1] ? w0[31:16] : w0[15:0]. A halfword is compressed iff h[1:0] != 2'b11.
  - pc[1]=0, h compressed: needs w0; emit {16'h0,h}; pc+=2; no pop.
  - pc[1]=0, h not compressed: needs w0; emit w0; pc+=4; pop w0.
  - pc[1]=1, h compressed: needs w0; emit {16'h0,h}; pc+=2; pop w0.
  - pc[1]=1, h not compressed: needs w0 and w1; emit {w1[15:0],w0[31:16]}; pc+=4; pop w0 only, so w1 becomes the head.
  - instrValidIF = required entries present && !redirectEn.
  - pcIF = pc; pc and the FIFO advance only when instrValidIF && instrReadyIF.
- Latency: first request in the first cycle after reset release. The word is sampled at the end of cycle 1, so instrValidIF=1 in cycle 2.
- Throughput: one instruction per cycle while the FIFO stays fed. A straddling 32-bit instruction waits until w1 arrives.
- Redirect (priority over handshake and push):
  - Same cycle: instrValidIF=0, pmReq=0, in-flight response dropped.
  - Next edge: FIFO cleared, pc={redirectPc[31:1],1'b0}, fetchAddr={redirectPc[31:2],2'b00}, reqPending=0.
  - If redirectPc[1]=1, the low half of the first word is discarded by alignment.
  - Redirect-to-valid latency is 2 cycles (3 for a straddling first instruction).
- Simultaneous push and pop in one cycle is legal; count is unchanged.
- The FIFO never overflows (issue is gated by occupancy); pop is never issued on empty (valid gated).
- An assertion flags a push while count==FETCH_DEPTH.

Decomposition:
- loopyV_data_types gains:
  - FETCH_DEPTH_DEFAULT and RESET_PC_DEFAULT constants.
  - Function is_compressed(logic [15:0]).
  - typedef fetch_word_t (32-bit word).
- Sub-module fetch_word_fifo (parameterised depth) provides:
  - Synchronous clear.
  - Push/pop.
  - Head and head+1 peek ports.
  - Count output.
- The aligner and request logic stay in if_fetch_align.

Test Plan:
1. Reset release with memory holding 32'h0000_0013 (NOP) at every word, ready=1 -> pmAddr 0,4,8..., first instrValidIF in cycle 2 with pcIF=0, then pcIF=4,8,... one per cycle.
2. Word 0 = 32'h4501_4081 (two compressed) -> instrIF=32'h0000_4081 at pcIF=0, then 32'h0000_4501 at pcIF=2, both with instrCompressedIF=1.
3. Straddle: word0 = {16'h0513, 16'h4081}, word1 = {16'h0001, 16'h0000} -> pc 0 emits compressed 16'h4081, then pc 2 emits 32'h0000_0513 with instrCompressedIF=0, and pc advances to 6.
4. instrReadyIF=0 for 10 cycles -> pmReq stops after the FIFO holds FETCH_DEPTH words, instrIF/pcIF stay stable, no word is lost when ready returns.
5. redirectEn with redirectPc=32'h0000_0102 while a request is in flight -> that cycle instrValidIF=0 and pmReq=0, stale word dropped, next pmAddr=0x100, first valid pcIF=0x102.
6. rst asserted mid-stream with a full FIFO -> next cycle instrValidIF=0, pmReq=0, and the restart from RESET_PC matches scenario 1.
